// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit.
//   - Default widths for PC/branch target, register specifiers and counters.
//   - FSM state encoding for the hazard controller.
package hazard_control_unit_pkg;

  localparam int unsigned ADDRESS_WIDTH  = 12;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned COUNT_WIDTH    = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of the hazard-unit pipeline signals.
//   master : pipeline side, drives ID/EX/MEM status and receives controls.
//   slave  : hazard unit side, receives status and drives stall/flush/redirect.
interface hazard_control_unit_if #(
  parameter int unsigned address_width  = hazard_control_unit_pkg::ADDRESS_WIDTH,
  parameter int unsigned reg_addr_width = hazard_control_unit_pkg::REG_ADDR_WIDTH,
  parameter int unsigned count_width    = hazard_control_unit_pkg::COUNT_WIDTH
) ();

  logic [reg_addr_width-1:0] id_rs1;
  logic [reg_addr_width-1:0] id_rs2;
  logic                      idex_mem_read;
  logic [reg_addr_width-1:0] idex_rd;
  logic                      exmem_branch;
  logic                      exmem_zero;
  logic [address_width-1:0]  exmem_target;
  logic                      stall;
  logic                      flush;
  logic                      pc_src;
  logic [address_width-1:0]  branch_target;
  logic [count_width-1:0]    stall_count;
  logic [count_width-1:0]    flush_count;

  modport master (
    output id_rs1, id_rs2, idex_mem_read, idex_rd,
           exmem_branch, exmem_zero, exmem_target,
    input  stall, flush, pc_src, branch_target, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, idex_mem_read, idex_rd,
           exmem_branch, exmem_zero, exmem_target,
    output stall, flush, pc_src, branch_target, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
//   clk     : clock
//   rst     : async reset, clears the count
//   en_i    : count one when high
//   count_o : current count, holds at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = hazard_control_unit_pkg::COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall and branch-redirect controller for a 5-stage pipeline.
//   clk, reset            : clock, async active-high reset
//   id_rs1/id_rs2         : source registers of the instruction in ID
//   idex_mem_read/idex_rd : load flag and destination of the instruction in EX
//   exmem_branch/zero     : branch flag and condition of the instruction in MEM
//   exmem_target          : branch target computed in MEM
//   stall                 : hold PC and IF/ID, bubble into ID/EX
//   flush, pc_src         : redirect Fetch and clear IF/ID, ID/EX, EX/MEM
//   branch_target         : redirect address (always follows exmem_target)
//   stall_count/flush_count : saturating event counters
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned address_width  = ADDRESS_WIDTH,
  parameter int unsigned reg_addr_width = REG_ADDR_WIDTH,
  parameter int unsigned count_width    = COUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [reg_addr_width-1:0] id_rs1,
  input  logic [reg_addr_width-1:0] id_rs2,
  input  logic                      idex_mem_read,
  input  logic [reg_addr_width-1:0] idex_rd,
  input  logic                      exmem_branch,
  input  logic                      exmem_zero,
  input  logic [address_width-1:0]  exmem_target,
  output logic                      stall,
  output logic                      flush,
  output logic                      pc_src,
  output logic [address_width-1:0]  branch_target,
  output logic [count_width-1:0]    stall_count,
  output logic [count_width-1:0]    flush_count
);

  hcu_state_e state_q;
  logic       taken;
  logic       hazard;

  // In REDIRECT the MEM stage holds a flushed bubble, so its branch
  // signals are stale and must not trigger a second redirect.
  assign taken = ~reset & exmem_branch & exmem_zero & (state_q != REDIRECT);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign hazard = idex_mem_read & (idex_rd != '0) &
                  ((idex_rd == id_rs1) | (idex_rd == id_rs2));

  // Redirect wins over stall: Fetch discards next_pc while stall is high.
  assign stall = ~reset & hazard & ~taken & (state_q == RUN);

  assign flush         = taken;
  assign pc_src        = taken;
  assign branch_target = exmem_target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (taken) begin
            state_q <= REDIRECT;
          end else if (stall) begin
            state_q <= STALL;
          end else begin
            state_q <= RUN;
          end
        end
        STALL:    state_q <= taken ? REDIRECT : RUN;
        REDIRECT: state_q <= RUN;
        default:  state_q <= RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(count_width)) u_stall_cnt (
    .clk     (clk),
    .rst     (reset),
    .en_i    (stall),
    .count_o (stall_count)
  );

  sat_counter #(.WIDTH(count_width)) u_flush_cnt (
    .clk     (clk),
    .rst     (reset),
    .en_i    (taken),
    .count_o (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized self-checking bench for hazard_control_unit. A second, narrow
// counter instance shares the stimulus so saturation is reached quickly.
module tb_hazard_control_unit;
  import hazard_control_unit_pkg::*;

  localparam int unsigned NARROW_W   = 5;
  localparam int unsigned WIDE_MAX   = 65535;
  localparam int unsigned NARROW_MAX = 31;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_control_unit_if #(
    .address_width (12),
    .reg_addr_width(5),
    .count_width   (16)
  ) bus ();

  logic                stall_n, flush_n, pc_src_n;
  logic [11:0]         bt_n;
  logic [NARROW_W-1:0] stall_count_n, flush_count_n;

  hazard_control_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .idex_mem_read (bus.idex_mem_read),
    .idex_rd       (bus.idex_rd),
    .exmem_branch  (bus.exmem_branch),
    .exmem_zero    (bus.exmem_zero),
    .exmem_target  (bus.exmem_target),
    .stall         (bus.stall),
    .flush         (bus.flush),
    .pc_src        (bus.pc_src),
    .branch_target (bus.branch_target),
    .stall_count   (bus.stall_count),
    .flush_count   (bus.flush_count)
  );

  hazard_control_unit #(.count_width(NARROW_W)) u_dut_narrow (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .idex_mem_read (bus.idex_mem_read),
    .idex_rd       (bus.idex_rd),
    .exmem_branch  (bus.exmem_branch),
    .exmem_zero    (bus.exmem_zero),
    .exmem_target  (bus.exmem_target),
    .stall         (stall_n),
    .flush         (flush_n),
    .pc_src        (pc_src_n),
    .branch_target (bt_n),
    .stall_count   (stall_count_n),
    .flush_count   (flush_count_n)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model: the unit is "busy" for one cycle after a stall or a
  // redirect; counters are plain integers clamped at their maximum.
  bit          m_after_redirect;
  bit          m_after_stall;
  int unsigned m_sc, m_fc, m_sc_n, m_fc_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit mr, input int unsigned rd, input int unsigned rs1,
                       input int unsigned rs2, input bit br, input bit z,
                       input int unsigned tgt);
    bus.idex_mem_read = mr;
    bus.idex_rd       = 5'(rd);
    bus.id_rs1        = 5'(rs1);
    bus.id_rs2        = 5'(rs2);
    bus.exmem_branch  = br;
    bus.exmem_zero    = z;
    bus.exmem_target  = 12'(tgt);
  endtask

  // Check current outputs against the model, then advance the model across
  // the coming rising edge (unless reset is holding everything).
  task automatic step(input string tag);
    bit e_taken, e_hazard, e_stall;
    e_taken = 1'b0;
    e_stall = 1'b0;
    if (reset) begin
      m_after_redirect = 1'b0;
      m_after_stall    = 1'b0;
      m_sc = 0; m_fc = 0; m_sc_n = 0; m_fc_n = 0;
    end else begin
      e_taken  = bus.exmem_branch && bus.exmem_zero && !m_after_redirect;
      e_hazard = bus.idex_mem_read && (bus.idex_rd != 0) &&
                 ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));
      e_stall  = e_hazard && !e_taken && !m_after_redirect && !m_after_stall;
    end
    check_eq({tag, ".stall"},  32'(bus.stall),  32'(e_stall));
    check_eq({tag, ".flush"},  32'(bus.flush),  32'(e_taken));
    check_eq({tag, ".pc_src"}, 32'(bus.pc_src), 32'(e_taken));
    check_eq({tag, ".target"}, 32'(bus.branch_target), 32'(bus.exmem_target));
    check_eq({tag, ".stall_count"}, 32'(bus.stall_count), m_sc);
    check_eq({tag, ".flush_count"}, 32'(bus.flush_count), m_fc);
    check_eq({tag, ".n_stall_count"}, 32'(stall_count_n), m_sc_n);
    check_eq({tag, ".n_flush_count"}, 32'(flush_count_n), m_fc_n);
    if (!reset) begin
      if (e_stall) begin
        if (m_sc < WIDE_MAX)   m_sc++;
        if (m_sc_n < NARROW_MAX) m_sc_n++;
      end
      if (e_taken) begin
        if (m_fc < WIDE_MAX)   m_fc++;
        if (m_fc_n < NARROW_MAX) m_fc_n++;
      end
      m_after_redirect = e_taken;
      m_after_stall    = e_stall;
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    #1 step(tag);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 12'h123);
    @(negedge clk);
    #1 step("reset");
    @(negedge clk);
    reset = 1'b0;
    #1 step("post_reset");

    // Load-use hazard: one stall cycle, then a cycle in STALL with stall low.
    @(negedge clk); drive(1, 5, 5, 0, 0, 0, 0); #1 step("lu_1");
    @(negedge clk); #1 step("lu_2");
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1 step("lu_3");
    check_eq("lu.count_is_1", 32'(bus.stall_count), 32'd1);

    // Load to x0 must never stall.
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0); #1 step("x0_1");
    check_eq("x0.stall_low", 32'(bus.stall), 32'd0);
    @(negedge clk); #1 step("x0_2");

    // Taken branch: immediate redirect, then REDIRECT with inputs held.
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 12'h040); #1 step("br_1");
    check_eq("br.target_040", 32'(bus.branch_target), 32'h040);
    @(negedge clk); #1 step("br_2");
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1 step("br_3");
    check_eq("br.flush_count_1", 32'(bus.flush_count), 32'd1);

    // Hazard and taken branch together: redirect wins.
    @(negedge clk); drive(1, 7, 7, 3, 1, 1, 12'h2a4); #1 step("both_1");
    @(negedge clk); #1 step("both_2");
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1 step("both_3");

    // Async reset during REDIRECT.
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 12'h3f0); #1 step("rr_1");
    @(posedge clk);
    #2 reset = 1'b1;
    #1 step("rr_in_reset");
    #1 reset = 1'b0;
    cycle("rr_after");
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1 step("rr_idle");

    // Random traffic with occasional async reset pulses.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive($urandom_range(1, 0) == 1, $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(3, 0), $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
            $urandom_range(4095, 0));
      if ($urandom_range(49, 0) == 0) begin
        reset = 1'b1;
        #1 step("rnd_reset");
        #1 reset = 1'b0;
      end
      #1 step("rnd");
    end

    // Saturation: continuous hazard, then continuous taken branch.
    @(negedge clk); drive(1, 9, 9, 9, 0, 0, 0); #1 step("sat_s");
    for (int i = 0; i < 80; i++) cycle("sat_s");
    check_eq("sat.narrow_stall_max", 32'(stall_count_n), 32'(NARROW_MAX));
    @(negedge clk); drive(0, 0, 0, 0, 1, 1, 12'h7ff); #1 step("sat_f");
    for (int i = 0; i < 80; i++) cycle("sat_f");
    check_eq("sat.narrow_flush_max", 32'(flush_count_n), 32'(NARROW_MAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter address_width, default 12, width of the PC/branch target.
REQ-002 SHALL have parameter reg_addr_width, default 5, width of register specifiers.
REQ-003 SHALL have parameter count_width, default 16, width of performance counters.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port id_rs1  input  reg_addr_width  source register 1 of the instruction in ID.
REQ-007 SHALL have port id_rs2  input  reg_addr_width  source register 2 of the instruction in ID.
REQ-008 SHALL have port idex_mem_read  input  1  instruction in EX is a load.
REQ-009 SHALL have port idex_rd  input  reg_addr_width  destination register of the instruction in EX.
REQ-010 SHALL have port exmem_branch  input  1  instruction in MEM is a branch.
REQ-011 SHALL have port exmem_zero  input  1  ALU zero flag from MEM (branch condition met).
REQ-012 SHALL have port exmem_target  input  address_width  computed branch target in MEM.
REQ-013 SHALL have port stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-014 SHALL have port flush  output  1  clear IF/ID, ID/EX, EX/MEM to bubbles.
REQ-015 SHALL have port pc_src  output  1  Fetch selects branch_target.
REQ-016 SHALL have port branch_target  output  address_width  redirect address to Fetch.
REQ-017 SHALL have port stall_count  output  count_width  saturating count of stall cycles.
REQ-018 SHALL have port flush_count  output  count_width  saturating count of redirects.

Function
REQ-019 SHALL implement FSM states RUN, STALL, REDIRECT; reset state RUN.
REQ-020 taken = exmem_branch & exmem_zero & (state != REDIRECT); branch_target SHALL equal exmem_target combinationally.
REQ-021 pc_src and flush SHALL equal taken, combinationally, in the same cycle (zero latency).
REQ-022 hazard = idex_mem_read & (idex_rd != 0) & (idex_rd == id_rs1 | idex_rd == id_rs2), computed combinationally.
REQ-023 stall SHALL equal hazard & ~taken & (state == RUN); branch redirect takes priority because Fetch drops next_pc while stall is high.
REQ-024 RUN -> REDIRECT on taken; RUN -> STALL on stall; else stay in RUN.
REQ-025 STALL SHALL last exactly one cycle, stall low in STALL, then -> RUN; taken in STALL -> REDIRECT.
REQ-026 REDIRECT SHALL last exactly one cycle with stall, flush, pc_src all low (EX/MEM holds a bubble), then -> RUN.
REQ-027 stall_count SHALL increment by 1 each cycle stall is high, saturating at all-ones.
REQ-028 flush_count SHALL increment by 1 each cycle taken is high, saturating at all-ones.
REQ-029 idex_rd == 0 SHALL never cause a stall, including a load to x0.

Reset
REQ-030 reset high SHALL immediately force state RUN, stall_count 0, flush_count 0, independent of clk.
REQ-031 While reset is high, stall, flush, and pc_src SHALL be 0; branch_target SHALL still follow exmem_target.
REQ-032 Reset asserted mid-STALL or mid-REDIRECT SHALL abandon the state; first post-reset cycle is RUN.

Structure
REQ-033 State encodings (RUN=2'd0, STALL=2'd1, REDIRECT=2'd2) and the default widths SHALL live in a shared pipeline package.
REQ-034 A single sub-module sat_counter (enable, saturating, async reset) SHALL be instantiated twice for the counters.

Verification
REQ-035 idex_mem_read=1, idex_rd=5, id_rs1=5 -> stall=1 for one cycle, stall=0 next cycle, stall_count=1.
REQ-036 idex_mem_read=1, idex_rd=0, id_rs2=0 -> stall=0, stall_count=0.
REQ-037 exmem_branch=1, exmem_zero=1, exmem_target=12'h040 -> pc_src=1, flush=1, branch_target=12'h040 same cycle; next cycle pc_src=0 while inputs held; flush_count=1.
REQ-038 Load-use hazard (rd=7=rs1) and taken branch in the same cycle -> stall=0, pc_src=1, state REDIRECT.
REQ-039 Force stall_count to all-ones via 65536 stall cycles -> count stays 16'hFFFF.
REQ-040 Assert reset asynchronously mid-REDIRECT -> outputs 0 and counters 0 before the next clk edge; RUN after release.
